bus_slave_port: RTL

//  Slave-side responder of the system bus, at the far end from the address decoder.

---
 rtl/bus_slave_port_if.sv | 22 ++
 rtl/bus_slave_port.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bus_slave_port_if.sv
// Serial system-bus link between a master and one slave port.
// Master shifts address/data in; slave returns serial read data.
interface bus_slave_port_if;
  logic slave_sel;
  logic m_valid;
  logic m_wdata;
  logic m_mode;
  logic s_ready;
  logic s_valid;
  logic s_rdata;
  logic s_done;

  modport master (
    output slave_sel, m_valid, m_wdata, m_mode,
    input  s_ready, s_valid, s_rdata, s_done
  );

  modport slave (
    input  slave_sel, m_valid, m_wdata, m_mode,
    output s_ready, s_valid, s_rdata, s_done
  );
endinterface

// File: rtl/bus_slave_port.sv
// Serial bus slave responder: shifts in address/write data, accesses
// a local RAM and shifts read data back out, LSB first.
module bus_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_slave_port_if.slave  bus
);

  localparam int IW   = $clog2(MEM_DEPTH);
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ?
                        ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int unsigned DEPTH_U = MEM_DEPTH;

  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] D_END  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    MEMACC,
    RDATA
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    mode_q, mode_d;
  logic                    idle_q, idle_d;
  logic                    valid_q, valid_d;
  logic                    rdata_q, rdata_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   wdata;
  logic [ADDR_WIDTH-1:0]   addr_sh;
  logic [IW-1:0]           idx;
  logic                    in_range;
  logic                    we;

  // Upper address bits only take part in the range check.
  assign idx      = addr_q[IW-1:0];
  assign in_range = 32'(addr_q) < DEPTH_U;
  assign wdata    = {bus.m_wdata, data_q[DATA_WIDTH-1:1]};
  assign addr_sh  = {bus.m_wdata, addr_q[ADDR_WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    rdata_d = 1'b0;
    done_d  = 1'b0;
    we      = 1'b0;
    if (state_q != IDLE && !bus.slave_sel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.slave_sel && bus.m_valid) begin
            addr_d  = addr_sh;
            mode_d  = bus.m_mode;
            cnt_d   = C_ONE;
            state_d = ADDR;
          end
        end
        ADDR: begin
          if (bus.m_valid) begin
            addr_d = addr_sh;
            if (cnt_q == A_LAST) begin
              cnt_d   = '0;
              state_d = mode_q ? WDATA : MEMACC;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        end
        WDATA: begin
          if (bus.m_valid) begin
            data_d = wdata;
            if (cnt_q == D_LAST) begin
              we      = in_range;
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        end
        MEMACC: begin
          data_d  = in_range ? mem[idx] : '0;
          cnt_d   = '0;
          state_d = RDATA;
        end
        RDATA: begin
          if (cnt_q == D_END) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            valid_d = 1'b1;
            rdata_d = data_q[0];
            data_d  = data_q >> 1;
            done_d  = (cnt_q == D_LAST);
            cnt_d   = cnt_q + C_ONE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      idle_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign bus.s_ready = idle_q & bus.slave_sel;
  assign bus.s_valid = valid_q;
  assign bus.s_rdata = rdata_q;
  assign bus.s_done  = done_q;

endmodule
